// File: rtl/alu_pkg.sv
// Shared types for the ALU sequencing front-end.
// Optional build macro ALU_CTRL_ZFLAG_EN adds a zero flag to each result entry.
package alu_pkg;

    localparam int ALU_W = 16;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_t;

    typedef struct packed {
        logic [ALU_W-1:0] data;
        logic             cout;
`ifdef ALU_CTRL_ZFLAG_EN
        logic             zero;
`endif
    } alu_res_t;

endpackage

// File: rtl/alu_ctrl_if.sv
// Command and result handshake channels of alu_ctrl.
// master = issue/consume side, slave = the controller.
// Optional build macro ALU_CTRL_ZFLAG_EN adds res_zero to the result channel.
interface alu_ctrl_if #(
    parameter int W = 16
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;

    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_cout;
`ifdef ALU_CTRL_ZFLAG_EN
    logic         res_zero;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_data, res_cout, res_zero
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_data, res_cout, res_zero
    );
`else
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_data, res_cout
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_data, res_cout
    );
`endif
endinterface

// File: rtl/alu_res_fifo.sv
// Small synchronous result FIFO: power-of-two depth, naturally wrapping
// pointers, occupancy counter, simultaneous push/pop keeps occupancy.
// Storage is reset so the head reads as zero out of reset.
module alu_res_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  alu_res_t push_data,
    input  logic     pop,
    output alu_res_t head,
    output logic     full,
    output logic     empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    alu_res_t        mem_q [DEPTH];
    alu_res_t        mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_push;
    logic            do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state registers; reset flushes contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_ctrl.sv
// Sequencing front-end for the combinational bit-slice ALU.
// Registers a command into the ALU inputs, captures o/cout one cycle later
// into a result FIFO and counts completed operations.
// Optional build macro ALU_CTRL_ZFLAG_EN adds a per-result zero flag (res_zero).
//
// state | meaning
// IDLE  | waiting for a command; ready when the FIFO has room (or pops now)
// EXEC  | ALU inputs stable; result captured at the closing edge
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int W          = ALU_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_ctrl_if.slave    bus,
    output logic [1:0]   alu_op,
    output logic [W-1:0] alu_i0,
    output logic [W-1:0] alu_i1,
    input  logic [W-1:0] alu_o,
    input  logic         alu_cout,
    output logic [15:0]  ops_done
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EXEC = 1'b1;

    logic [0:0]   state_q, state_d;
    alu_op_t      op_q, op_d;
    logic [W-1:0] i0_q, i0_d;
    logic [W-1:0] i1_q, i1_d;
    logic [15:0]  ops_done_q, ops_done_d;
    logic         live_q, live_d;

    logic         push;
    logic         pop;
    logic         accept;
    logic         fifo_full;
    logic         fifo_empty;
    alu_res_t     push_res;
    alu_res_t     head_res;

    // live_q keeps cmd_ready low until the first edge after reset release.
    assign live_d        = 1'b1;
    assign pop           = bus.res_valid && bus.res_ready;
    assign bus.cmd_ready = live_q && (state_q == S_IDLE) && (!fifo_full || pop);
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    assign alu_op   = op_q;
    assign alu_i0   = i0_q;
    assign alu_i1   = i1_q;
    assign ops_done = ops_done_q;

    assign bus.res_valid = !fifo_empty;
    assign bus.res_data  = head_res.data;
    assign bus.res_cout  = head_res.cout;
`ifdef ALU_CTRL_ZFLAG_EN
    assign bus.res_zero  = head_res.zero;
`endif

    // Pack the raw ALU outputs into a FIFO entry.
    always_comb begin
        push_res      = '0;
        push_res.data = alu_o;
        push_res.cout = alu_cout;
`ifdef ALU_CTRL_ZFLAG_EN
        push_res.zero = (alu_o == '0);
`endif
    end

    // FSM: capture operands on accept, push the result one cycle later.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        i0_d       = i0_q;
        i1_d       = i1_q;
        ops_done_d = ops_done_q;
        push       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = alu_op_t'(bus.cmd_op);
                    i0_d    = bus.cmd_a;
                    i1_d    = bus.cmd_b;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                push       = 1'b1;
                ops_done_d = ops_done_q + 16'd1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Controller state registers; operand registers hold between commands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= OP_AND;
            i0_q       <= '0;
            i1_q       <= '0;
            ops_done_q <= '0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            i0_q       <= i0_d;
            i1_q       <= i1_d;
            ops_done_q <= ops_done_d;
            live_q     <= live_d;
        end
    end

    alu_res_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_res),
        .pop       (pop),
        .head      (head_res),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl with a behavioural ALU and result model.
module tb_alu_ctrl;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   alu_op;
    logic [W-1:0] alu_i0, alu_i1, alu_o;
    logic         alu_cout;
    logic [15:0]  ops_done;
    logic [W:0]   alu_sum;

    int           checks   = 0;
    int           failures = 0;
    logic [W:0]   exp_q[$];
    logic [15:0]  exp_ops;
    time          accept_t;
    time          t1;

    always #5 clk = ~clk;

    alu_ctrl_if #(.W(W)) bus ();

    alu_ctrl #(.W(W), .FIFO_DEPTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .alu_op   (alu_op),
        .alu_i0   (alu_i0),
        .alu_i1   (alu_i1),
        .alu_o    (alu_o),
        .alu_cout (alu_cout),
        .ops_done (ops_done)
    );

    // Combinational ALU stand-in: SUB as a + ~b + 1, cout is the adder carry.
    always_comb begin
        alu_sum = '0;
        case (alu_op)
            2'b00:   alu_sum = {1'b0, alu_i0 & alu_i1};
            2'b01:   alu_sum = {1'b0, alu_i0 | alu_i1};
            2'b10:   alu_sum = {1'b0, alu_i0} + {1'b0, alu_i1};
            default: alu_sum = {1'b0, alu_i0} + {1'b0, ~alu_i1} + 17'd1;
        endcase
        alu_o    = alu_sum[W-1:0];
        alu_cout = alu_sum[W];
    end

    // Expected {cout, data} from plain integer arithmetic.
    function automatic logic [W:0] ref_res(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        int ia, ib, s;
        ia = int'(a);
        ib = int'(b);
        case (op)
            0:       return {1'b0, a & b};
            1:       return {1'b0, a | b};
            2: begin
                s = ia + ib;
                return {(s >= 65536), W'(s)};
            end
            default: begin
                s = ia - ib;
                return {(ia >= ib), W'(s)};
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'(op);
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("send_wait", 32'(n < 50), 32'd1);
        if (n < 50) begin
            step();
            accept_t = $time;
            exp_q.push_back(ref_res(op, a, b));
            exp_ops++;
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic check_head(input string tag);
        logic [W:0] e;
        chk({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q[0];
            chk({tag, "_data"}, 32'(bus.res_data), 32'(e[W-1:0]));
            chk({tag, "_cout"}, 32'(bus.res_cout), 32'(e[W]));
`ifdef ALU_CTRL_ZFLAG_EN
            chk({tag, "_zero"}, 32'(bus.res_zero), 32'(e[W-1:0] == '0));
`endif
        end
    endtask

    task automatic pop_one(input string tag);
        check_head(tag);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb, ta;
        int           rop;

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.res_ready = 1'b0;
        exp_ops       = '0;
        repeat (3) step();

        // Reset values
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_data", 32'(bus.res_data), 32'd0);
        chk("rst_res_cout", 32'(bus.res_cout), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_i0", 32'(alu_i0), 32'd0);
        chk("rst_alu_i1", 32'(alu_i1), 32'd0);
        chk("rst_ops_done", 32'(ops_done), 32'd0);
`ifdef ALU_CTRL_ZFLAG_EN
        chk("rst_res_zero", 32'(bus.res_zero), 32'd0);
`endif
        rst_n = 1'b1;
        step();
        chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // ADD wrapping to zero with carry
        send(2, 16'hFFFF, 16'h0001);
        chk("add_alu_op", 32'(alu_op), 32'd2);
        chk("add_alu_i0", 32'(alu_i0), 32'hFFFF);
        chk("add_alu_i1", 32'(alu_i1), 32'h0001);
        chk("add_exec_ready", 32'(bus.cmd_ready), 32'd0);
        chk("add_not_yet_valid", 32'(bus.res_valid), 32'd0);
        step();
        check_head("add_wrap");
        chk("add_res_data0", 32'(bus.res_data), 32'h0000);
        chk("add_ops_done", 32'(ops_done), 32'd1);
        pop_one("add_wrap_pop");
        chk("add_popped", 32'(bus.res_valid), 32'd0);
        chk("hold_alu_i0", 32'(alu_i0), 32'hFFFF);

        // Back-to-back with consumer always ready
        bus.res_ready = 1'b1;
        send(0, 16'h0F0F, 16'h00FF);
        t1 = accept_t;
        step();
        check_head("and");
        chk("and_explicit", 32'(bus.res_data), 32'h000F);
        void'(exp_q.pop_front());
        send(1, 16'hF000, 16'h000F);
        chk("b2b_spacing", 32'(accept_t - t1), 32'd20);
        step();
        check_head("or");
        chk("or_explicit", 32'(bus.res_data), 32'hF00F);
        void'(exp_q.pop_front());
        step();
        bus.res_ready = 1'b0;
        chk("b2b_drained", 32'(bus.res_valid), 32'd0);

        // Fill FIFO, third command waits, accepted on the same-cycle pop
        send(2, 16'($urandom), 16'($urandom));
        ra = 16'($urandom);
        send(3, ra, 16'($urandom));
        step();
        ta = 16'($urandom);
        rb = 16'($urandom);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd2;
        bus.cmd_a     = ta;
        bus.cmd_b     = rb;
        step();
        step();
        chk("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("full_hold_i0", 32'(alu_i0), 32'(ra));
        chk("full_ops_done", 32'(ops_done), 32'(exp_ops));
        check_head("full_head");
        bus.res_ready = 1'b1;
        #1;
        chk("pop_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(ref_res(2, ta, rb));
        exp_ops++;
        chk("third_alu_i0", 32'(alu_i0), 32'(ta));
        step();
        pop_one("full_second");
        pop_one("full_third");
        chk("full_empty", 32'(bus.res_valid), 32'd0);
        chk("full_ops", 32'(ops_done), 32'(exp_ops));

        // SUB, both with and without borrow
        send(3, 16'h0005, 16'h0003);
        step();
        check_head("sub");
        chk("sub_explicit", 32'(bus.res_data), 32'h0002);
        pop_one("sub_pop");
        send(3, 16'h0003, 16'h0005);
        step();
        pop_one("sub_borrow");

        // Reset during EXEC discards the in-flight result
        send(2, 16'h1234, 16'h1111);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_ops = '0;
        #1;
        chk("mid_rst_valid", 32'(bus.res_valid), 32'd0);
        chk("mid_rst_ops", 32'(ops_done), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_mid_valid", 32'(bus.res_valid), 32'd0);
        chk("post_mid_ops", 32'(ops_done), 32'd0);
        chk("post_mid_i0", 32'(alu_i0), 32'd0);
        chk("post_mid_ready", 32'(bus.cmd_ready), 32'd1);
        step();
        chk("post_mid_valid2", 32'(bus.res_valid), 32'd0);

        // Randomised traffic against the model
        for (int k = 0; k < 40; k++) begin
            rop = int'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            rb  = ($urandom_range(0, 5) == 0) ? ra : 16'($urandom);
            send(rop, ra, rb);
            step();
            chk("rand_ops", 32'(ops_done), 32'(exp_ops));
            if (exp_q.size() >= 2 || ($urandom_range(0, 1) == 1 && exp_q.size() > 0)) begin
                pop_one("rand");
            end
        end
        while (exp_q.size() > 0) pop_one("rand_drain");
        chk("rand_empty", 32'(bus.res_valid), 32'd0);

        // ops_done wrap from 0xFFFF to 0
        force dut.ops_done_q = 16'hFFFE;
        #1;
        release dut.ops_done_q;
        exp_ops = 16'hFFFE;
        send(0, 16'h1111, 16'h2222);
        step();
        chk("ops_ffff", 32'(ops_done), 32'hFFFF);
        pop_one("wrap_a");
        send(1, 16'h0000, 16'h0000);
        step();
        chk("ops_wrap", 32'(ops_done), 32'h0000);
        chk("ops_wrap_model", 32'(ops_done), 32'(exp_ops));
        pop_one("wrap_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
